// File: rtl/mem_arb_pkg.sv
// Purpose : shared types and default sizing for the two-port SRAM arbiter.
// Latency : n/a (declarations only).
// Backpress: n/a.
package mem_arb_pkg;

    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_MAX_LOCK = 8;

    // Arbiter FSM: IDLE (no traffic last cycle), RR (round-robin), LOCK1 (m1 owns the SRAM)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RR    = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    // A byte address is out of range when any bit above the word-address field is set.
    function automatic logic addr_oor(input logic [31:0] addr, input int addr_w);
        return (addr >> (addr_w + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Purpose : two-way round-robin picker; a lone requester always wins, a tie goes to the
//           requester that was not granted last.  Ports: req[1:0] in, last in (1 = m1 won last), gnt[1:0] out.
// Latency : purely combinational.  Backpress: none; losers simply see gnt=0.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose : arbitrates CPU port m0 and loader/debug port m1 onto one single-port SRAM, with an
//           optional bounded m1 lock; ports m0_*/m1_* (req/we/addr/wdata in, gnt/rvalid/rdata/err out),
//           m1_lock in, DM_* SRAM side, clk + synchronous active-low rst.
// Latency : grant is combinational with the request; read/err responses arrive exactly one cycle later.
// Backpress: a requester that does not see gnt must hold its inputs; one grant per cycle sustained.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [31:0]       m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    input  logic              m1_lock,

    output logic              DM_enable,
    output logic              DM_write,
    output logic [ADDR_W-1:0] DM_address,
    output logic [DATA_W-1:0] DM_in,
    input  logic [DATA_W-1:0] DM_out
);

    localparam int               CNT_W      = $clog2(MAX_LOCK) + 1;
    localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(MAX_LOCK);

    arb_state_e       state_q, state_d;
    logic             last_q, last_d;          // 1 = m1 received the most recent grant
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [1:0]       rvalid_q, rvalid_d;
    logic [1:0]       err_q, err_d;

    logic [1:0]        rr_gnt;
    logic [1:0]        gnt;
    logic              any_req;
    logic              m0_oor, m1_oor;
    logic              win_we, win_oor;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // Byte-lane bits are meaningless to a word-wide SRAM.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{m0_addr[1:0], m1_addr[1:0]};

    assign any_req = m0_req | m1_req;
    assign m0_oor  = addr_oor(m0_addr, ADDR_W);
    assign m1_oor  = addr_oor(m1_addr, ADDR_W);

    rr_pick2 u_rr_pick2 (
        .req  ({m1_req, m0_req}),
        .last (last_q),
        .gnt  (rr_gnt)
    );

    // Grant select; everything downstream of gnt is silenced while reset is held.
    always_comb begin
        gnt = 2'b00;
        if (rst) begin
            if (state_q == LOCK1) begin
                gnt = {m1_req, 1'b0};
            end else begin
                gnt = rr_gnt;
            end
        end
    end

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    // Winner mux feeding the SRAM.
    always_comb begin
        win_we    = m0_we;
        win_oor   = m0_oor;
        win_addr  = m0_addr[ADDR_W+1:2];
        win_wdata = m0_wdata;
        if (gnt[1]) begin
            win_we    = m1_we;
            win_oor   = m1_oor;
            win_addr  = m1_addr[ADDR_W+1:2];
            win_wdata = m1_wdata;
        end
    end

    // Out-of-range accesses are still granted (so the requester can move on) but never reach the SRAM.
    always_comb begin
        DM_enable  = 1'b0;
        DM_write   = 1'b0;
        DM_address = '0;
        DM_in      = '0;
        if (gnt != 2'b00) begin
            DM_enable  = ~win_oor;
            DM_write   = ~win_oor & win_we;
            DM_address = win_addr;
            DM_in      = win_wdata;
        end
    end

    // FSM next state, round-robin pointer and lock counter.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        lock_cnt_d = lock_cnt_q;

        if (gnt[0]) last_d = 1'b0;
        if (gnt[1]) last_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (any_req) state_d = RR;
            end
            RR: begin
                if (!any_req) begin
                    state_d = IDLE;
                end else if (gnt[1] && m1_lock) begin
                    // The grant that opens the lock is the first locked grant of the session.
                    state_d    = LOCK1;
                    lock_cnt_d = CNT_W'(1);
                end
            end
            LOCK1: begin
                if (gnt[1] && lock_cnt_q != LOCK_LIMIT) begin
                    lock_cnt_d = lock_cnt_q + CNT_W'(1);
                end
                if (lock_cnt_d == LOCK_LIMIT) begin
                    // Session used up: hand the next contested cycle to m0.
                    state_d    = RR;
                    lock_cnt_d = '0;
                    last_d     = 1'b1;
                end else if (!m1_lock) begin
                    state_d    = RR;
                    lock_cnt_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    // Response tracking: reads and any out-of-range access answer one cycle after the grant.
    always_comb begin
        rvalid_d[0] = gnt[0] & (m0_oor | ~m0_we);
        rvalid_d[1] = gnt[1] & (m1_oor | ~m1_we);
        err_d[0]    = gnt[0] & m0_oor;
        err_d[1]    = gnt[1] & m1_oor;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            lock_cnt_q <= '0;
            rvalid_q   <= 2'b00;
            err_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
        end
    end

    // DM_out is only meaningful the cycle after an in-range read, so it is passed through only then.
    assign m0_rvalid = rst & rvalid_q[0];
    assign m1_rvalid = rst & rvalid_q[1];
    assign m0_err    = rst & err_q[0];
    assign m1_err    = rst & err_q[1];
    assign m0_rdata  = (rst & rvalid_q[0] & ~err_q[0]) ? DM_out : '0;
    assign m1_rdata  = (rst & rvalid_q[1] & ~err_q[1]) ? DM_out : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : directed bench for mem_arbiter with a reference model of the arbitration rules.
// Latency : model expects same-cycle grants and next-cycle responses.
// Backpress: requesters hold inputs until granted.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int ML = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
    logic [31:0]   m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          DM_enable, DM_write;
    logic [AW-1:0] DM_address;
    logic [DW-1:0] DM_in;
    logic [DW-1:0] DM_out = '0;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .m1_lock(m1_lock),
        .DM_enable(DM_enable), .DM_write(DM_write), .DM_address(DM_address),
        .DM_in(DM_in), .DM_out(DM_out)
    );

    // SRAM environment: one-cycle read latency, with a preload path usable during reset.
    logic [DW-1:0] sram [0:(1<<AW)-1];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_dat = '0;

    always @(posedge clk) begin
        if (pre_en) begin
            sram[pre_addr] <= pre_dat;
        end else if (DM_enable) begin
            if (DM_write) sram[DM_address] <= DM_in;
            else          DM_out <= sram[DM_address];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: ownership rules, response queue and memory image.
    bit            m_favour1;     // on a tie, m1 wins
    bit            m_locked;      // m1 holds an exclusive session
    int            m_lock_n;      // m1 grants issued in the current session
    bit            m_idle;        // previous cycle carried no request
    bit            p_vld [2];
    bit            p_err [2];
    logic [31:0]   p_dat [2];
    logic [DW-1:0] model_mem [0:(1<<AW)-1];

    always @(negedge clk) begin : model_chk
        logic        e_g0, e_g1, w_we, w_oor, oor0, oor1, was_locked;
        logic [31:0] w_addr, w_wdata;

        if (pre_en) model_mem[pre_addr] = pre_dat;

        oor0 = m0_addr[31:AW+2] != 0;
        oor1 = m1_addr[31:AW+2] != 0;
        if (!rst)                    begin e_g0 = 1'b0;        e_g1 = 1'b0;      end
        else if (m_locked)           begin e_g0 = 1'b0;        e_g1 = m1_req;    end
        else if (m0_req && m1_req)   begin e_g0 = !m_favour1;  e_g1 = m_favour1; end
        else                         begin e_g0 = m0_req;      e_g1 = m1_req;    end

        w_we    = e_g1 ? m1_we    : m0_we;
        w_addr  = e_g1 ? m1_addr  : m0_addr;
        w_wdata = e_g1 ? m1_wdata : m0_wdata;
        w_oor   = e_g1 ? oor1     : oor0;

        check("m0_gnt", 32'(m0_gnt), 32'(e_g0));
        check("m1_gnt", 32'(m1_gnt), 32'(e_g1));
        check("dm_enable", 32'(DM_enable), 32'((e_g0 || e_g1) && !w_oor));
        check("dm_write", 32'(DM_write), 32'((e_g0 || e_g1) && !w_oor && w_we));
        if (!rst) begin
            check("dm_address_rst", 32'(DM_address), 32'd0);
            check("dm_in_rst", DM_in, 32'd0);
        end else if (e_g0 || e_g1) begin
            check("dm_address", 32'(DM_address), 32'(w_addr[AW+1:2]));
            check("dm_in", DM_in, w_wdata);
        end

        check("m0_rvalid", 32'(m0_rvalid), 32'(rst && p_vld[0]));
        check("m0_err", 32'(m0_err), 32'(rst && p_err[0]));
        if (rst && p_vld[0]) check("m0_rdata", m0_rdata, p_dat[0]);
        check("m1_rvalid", 32'(m1_rvalid), 32'(rst && p_vld[1]));
        check("m1_err", 32'(m1_err), 32'(rst && p_err[1]));
        if (rst && p_vld[1]) check("m1_rdata", m1_rdata, p_dat[1]);

        if (!rst) begin
            m_favour1 = 1'b0;
            m_locked  = 1'b0;
            m_lock_n  = 0;
            m_idle    = 1'b1;
            p_vld     = '{1'b0, 1'b0};
            p_err     = '{1'b0, 1'b0};
        end else begin
            p_vld[0] = e_g0 && (oor0 || !m0_we);
            p_err[0] = e_g0 && oor0;
            p_dat[0] = oor0 ? 32'd0 : model_mem[m0_addr[AW+1:2]];
            p_vld[1] = e_g1 && (oor1 || !m1_we);
            p_err[1] = e_g1 && oor1;
            p_dat[1] = oor1 ? 32'd0 : model_mem[m1_addr[AW+1:2]];
            if (e_g0 && !oor0 && m0_we) model_mem[m0_addr[AW+1:2]] = m0_wdata;
            if (e_g1 && !oor1 && m1_we) model_mem[m1_addr[AW+1:2]] = m1_wdata;

            if (e_g0) m_favour1 = 1'b1;
            if (e_g1) m_favour1 = 1'b0;

            was_locked = m_locked;
            if (m_locked) begin
                if (e_g1) m_lock_n++;
                if (m_lock_n >= ML || !m1_lock) begin
                    m_locked = 1'b0;
                    m_lock_n = 0;
                end
            end else if (e_g1 && m1_lock && !m_idle) begin
                m_locked = 1'b1;
                m_lock_n = 1;
            end
            m_idle = !was_locked && !(m0_req || m1_req);
        end
    end

    task automatic do_reset();
        step();
        rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin : stimulus
        int ngnt;

        // Reset: requests present but every combinational output held low.
        step();
        m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h10; m1_addr = 32'h20;
        @(negedge clk);
        check("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        check("rst_m1_gnt", 32'(m1_gnt), 32'd0);
        check("rst_dm_enable", 32'(DM_enable), 32'd0);
        check("rst_dm_address", 32'(DM_address), 32'd0);
        step();
        m0_req = 1'b0; m1_req = 1'b0;
        pre_en = 1'b1; pre_addr = 16'd4; pre_dat = 32'h1234_5678;
        step();
        pre_addr = 16'd8; pre_dat = 32'hA5A5_0008;
        step();
        pre_en = 1'b0;
        @(negedge clk);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        check("rst_lock_cnt", 32'(dut.lock_cnt_q), 32'd0);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("rel_m0_rvalid", 32'(m0_rvalid), 32'd0);

        // Single read of word 4.
        step();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0010;
        @(negedge clk);
        check("rd_m0_gnt", 32'(m0_gnt), 32'd1);
        check("rd_dm_address", 32'(DM_address), 32'd4);
        step();
        m0_req = 1'b0;
        @(negedge clk);
        check("rd_m0_rvalid", 32'(m0_rvalid), 32'd1);
        check("rd_m0_rdata", m0_rdata, 32'h1234_5678);
        check("rd_m0_err", 32'(m0_err), 32'd0);

        // Contention straight after reset: m0, m1, m0, m1.
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("contend_gnt", {30'd0, m1_gnt, m0_gnt}, (c % 2 == 0) ? 32'd1 : 32'd2);
            step();
        end
        m0_req = 1'b0; m1_req = 1'b0;

        // Lock limit: m0, then 8 m1 grants, then m0.
        do_reset();
        m0_req = 1'b1; m1_req = 1'b1; m1_lock = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("lock_gnt", {30'd0, m1_gnt, m0_gnt}, (c == 0 || c == 9) ? 32'd1 : 32'd2);
            step();
        end
        m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;

        // Highest in-range word, then an out-of-range write from m1.
        step();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0003_FFFC; m0_wdata = 32'hBEEF_FFFF;
        @(negedge clk);
        check("edge_dm_enable", 32'(DM_enable), 32'd1);
        check("edge_dm_address", 32'(DM_address), 32'h0000_FFFF);
        step();
        m0_req = 1'b0; m0_we = 1'b0;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0004_0000; m1_wdata = 32'hDEAD_0000;
        @(negedge clk);
        check("oor_m1_gnt", 32'(m1_gnt), 32'd1);
        check("oor_dm_enable", 32'(DM_enable), 32'd0);
        step();
        m1_req = 1'b0; m1_we = 1'b0;
        @(negedge clk);
        check("oor_m1_rvalid", 32'(m1_rvalid), 32'd1);
        check("oor_m1_err", 32'(m1_err), 32'd1);
        check("oor_m1_rdata", m1_rdata, 32'd0);

        // Reset in the cycle after a read grant.
        step();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        @(negedge clk);
        check("mid_m0_gnt", 32'(m0_gnt), 32'd1);
        step();
        m0_req = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("mid_rst_rvalid", 32'(m0_rvalid), 32'd0);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rel_rvalid", 32'(m0_rvalid), 32'd0);
        check("mid_state", 32'(dut.state_q), 32'(IDLE));
        step();
        m0_req = 1'b1; m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
        @(negedge clk);
        check("mid_next_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        step();
        m0_req = 1'b0;
        step();
        m1_req = 1'b0;

        // Back-to-back writes of words 1..31.
        ngnt = 0;
        step();
        for (int i = 1; i <= 31; i++) begin
            m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'(i * 4); m0_wdata = 32'hC0DE_0000 + 32'(i);
            @(negedge clk);
            if (m0_gnt) ngnt++;
            step();
        end
        m0_req = 1'b0; m0_we = 1'b0;
        check("b2b_grants", 32'(ngnt), 32'd31);
        step();
        for (int i = 1; i <= 31; i++) begin
            check("b2b_mem", sram[i], 32'hC0DE_0000 + 32'(i));
        end

        // Read one back through the arbiter (value checked by the model).
        m0_req = 1'b1; m0_addr = 32'h0000_007C;
        step();
        m0_req = 1'b0;
        @(negedge clk);
        check("b2b_rd_rdata", m0_rdata, 32'hC0DE_001F);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
